// File: rtl/video_timing_gen_pkg.sv
// Shared types, default 640x480@60 timing and the colour-expansion helper
// for the video timing generator.
package video_timing_gen_pkg;

   typedef enum logic [1:0] {
      REG_ACTIVE,
      REG_FRONT,
      REG_SYNC,
      REG_BACK
   } region_t;

   // Timing flags carried alongside the pixel fetch latency.
   // Every flag is "asserted" = 1; polarity is applied at the output register.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
   } timing_bits_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   // Left-justify an in_bits-wide field into out_bits, filling the low bits
   // by repeating the field's MSBs (e.g. 3'b101 -> 8'b10110110).
   // Widths are elaboration constants at every call site; max 16 bits.
   function automatic logic [15:0] expand_colour(input logic [15:0] val,
                                                 input int in_bits,
                                                 input int out_bits);
      logic [15:0] res;
      int          src;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < out_bits) begin
            src = in_bits - 1 - (i % in_bits);
            res[out_bits-1-i] = val[src];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One video axis: free-running counter over ACTIVE+FRONT+SYNC+BACK positions
// with region decode. Used once for columns and once for lines.
module video_axis_counter
   import video_timing_gen_pkg::*;
#(
   parameter int CNT_W  = 11,
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_start,
   output region_t          region
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

   logic last;

   assign last     = (count == CNT_W'(TOTAL - 1));
   assign at_start = (count == '0);

   // Advance on inc, wrapping to 0 after the last back-porch position.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

   // Region boundaries: active, then front porch, sync pulse, back porch.
   always_comb begin
      region = REG_BACK;
      if (count < CNT_W'(ACTIVE))
         region = REG_ACTIVE;
      else if (count < CNT_W'(ACTIVE + FRONT))
         region = REG_FRONT;
      else if (count < CNT_W'(ACTIVE + FRONT + SYNC))
         region = REG_SYNC;
   end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable video timing generator and pixel output stage. Issues pixel
// requests ahead of display, then realigns sync/blank with the returned colour
// and expands it to DAC width.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FRONT   = DEF_H_FRONT,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BACK    = DEF_H_BACK,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FRONT   = DEF_V_FRONT,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BACK    = DEF_V_BACK,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   R_BITS    = 3,
   parameter int   G_BITS    = 3,
   parameter int   B_BITS    = 2,
   parameter int   OUT_BITS  = 8,
   parameter int   FETCH_LAT = 1,
   parameter int   CNT_W     = 11
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             ce,
   input  logic [R_BITS+G_BITS+B_BITS-1:0]  colour_in,
   output logic                             req_valid,
   output logic [CNT_W-1:0]                 req_x,
   output logic [CNT_W-1:0]                 req_y,
   output logic                             line_start,
   output logic                             frame_start,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             blank_n,
   output logic [OUT_BITS-1:0]              red,
   output logic [OUT_BITS-1:0]              green,
   output logic [OUT_BITS-1:0]              blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int C_BITS  = R_BITS + G_BITS + B_BITS;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_start;
   logic             v_start;
   logic             h_wrap;
   region_t          h_region;
   region_t          v_region;
   timing_bits_t     raw;
   timing_bits_t     dly;

   assign h_wrap = ce & (h_cnt == CNT_W'(H_TOTAL - 1));

   video_axis_counter #(
      .CNT_W  (CNT_W),
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h_axis (
      .clock    (clock),
      .reset    (reset),
      .inc      (ce),
      .count    (h_cnt),
      .at_start (h_start),
      .region   (h_region)
   );

   video_axis_counter #(
      .CNT_W  (CNT_W),
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v_axis (
      .clock    (clock),
      .reset    (reset),
      .inc      (h_wrap),
      .count    (v_cnt),
      .at_start (v_start),
      .region   (v_region)
   );

   // Request side: combinational from the counters. Pulses are qualified by
   // ce so a stalled position does not repeat them, and masked during reset.
   assign req_valid   = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
   assign req_x       = req_valid ? h_cnt : '0;
   assign req_y       = req_valid ? v_cnt : '0;
   assign line_start  = ce & ~reset & h_start & (v_region == REG_ACTIVE);
   assign frame_start = ce & ~reset & h_start & v_start;

   assign raw.hsync   = (h_region == REG_SYNC);
   assign raw.vsync   = (v_region == REG_SYNC);
   assign raw.visible = req_valid;

   // Delay timing flags by the pixel-source latency so they meet colour_in.
   generate
      if (FETCH_LAT == 0) begin : g_no_pipe
         assign dly = raw;
      end else begin : g_pipe
         timing_bits_t pipe [FETCH_LAT];

         // Shift register of timing flags, flushed to idle on reset.
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < FETCH_LAT; i++)
                  pipe[i] <= '0;
            end else if (ce) begin
               pipe[0] <= raw;
               for (int i = 1; i < FETCH_LAT; i++)
                  pipe[i] <= pipe[i-1];
            end
         end

         assign dly = pipe[FETCH_LAT-1];
      end
   endgenerate

   // Output register: polarity-applied syncs, blank and expanded colour.
   always_ff @(posedge clock) begin
      if (reset) begin
         hsync   <= ~HSYNC_POL;
         vsync   <= ~VSYNC_POL;
         blank_n <= 1'b0;
         red     <= '0;
         green   <= '0;
         blue    <= '0;
      end else if (ce) begin
         hsync   <= dly.hsync ? HSYNC_POL : ~HSYNC_POL;
         vsync   <= dly.vsync ? VSYNC_POL : ~VSYNC_POL;
         blank_n <= dly.visible;
         red     <= dly.visible ? OUT_BITS'(expand_colour(
                       16'(colour_in[C_BITS-1 -: R_BITS]), R_BITS, OUT_BITS)) : '0;
         green   <= dly.visible ? OUT_BITS'(expand_colour(
                       16'(colour_in[G_BITS+B_BITS-1 -: G_BITS]), G_BITS, OUT_BITS)) : '0;
         blue    <= dly.visible ? OUT_BITS'(expand_colour(
                       16'(colour_in[B_BITS-1:0]), B_BITS, OUT_BITS)) : '0;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (25 x 11) with a 3-cycle
// pixel source. A bench-side raster model pushes expected pixels into a
// scoreboard queue at request time; they are popped and compared when the
// output stage presents them.
module tb_video_timing_gen;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
   localparam int VA = 6,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
   localparam int LAT = 3;
   localparam int CW  = 11;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       vis;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          ce;
   logic [7:0]    colour_in;
   logic          req_valid;
   logic [CW-1:0] req_x, req_y;
   logic          line_start, frame_start;
   logic          hsync, vsync, blank_n;
   logic [7:0]    red, green, blue;

   exp_t sq[$];
   int   cx[$], cy[$];
   int   ls_clk[$], fs_en[$];
   int   mh, mv, cyc, en_cyc;
   int   compared = 0, mismatched = 0;
   bit   use_const = 0;
   int   hs_run, hs_falls, hs_bad, vs_low;
   logic hs_prev;

   video_timing_gen #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
      .R_BITS (3), .G_BITS (3), .B_BITS (2), .OUT_BITS (8),
      .FETCH_LAT (LAT), .CNT_W (CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ce          (ce),
      .colour_in   (colour_in),
      .req_valid   (req_valid),
      .req_x       (req_x),
      .req_y       (req_y),
      .line_start  (line_start),
      .frame_start (frame_start),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank_n     (blank_n),
      .red         (red),
      .green       (green),
      .blue        (blue)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pix(input int x, input int y);
      if (use_const) return 8'b101_011_11;
      return 8'((x * 37) + (y * 11) + 3);
   endfunction

   function automatic logic [7:0] ex3(input logic [2:0] v);
      return {v, v, v[2:1]};
   endfunction

   function automatic logic [7:0] ex2(input logic [1:0] v);
      return {v, v, v, v};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic clear_stats();
      hs_run = 0; hs_falls = 0; hs_bad = 0; vs_low = 0; hs_prev = 1'b1;
      ls_clk.delete();
      fs_en.delete();
   endtask

   // Output stage shows idle values for the first LAT+1 enabled cycles.
   task automatic model_reset();
      exp_t idle;
      idle = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};
      mh = 0; mv = 0; en_cyc = 0;
      sq.delete(); cx.delete(); cy.delete();
      for (int i = 0; i < LAT + 1; i++) sq.push_back(idle);
   endtask

   task automatic do_reset();
      reset = 1'b1; ce = 1'b0;
      tick(); tick();
      reset = 1'b0;
      model_reset();
      clear_stats();
   endtask

   // One clock: check request side and scoreboard on enabled cycles, feed
   // colour_in for the request issued LAT enabled cycles ago, advance model.
   task automatic cycle(input logic ce_v);
      exp_t e, o;
      logic [7:0] p;
      logic vis;
      int qx, qy;
      ce = ce_v;
      #1;
      if (ce_v) begin
         vis = (mh < HA) && (mv < VA);
         compared++;
         if (req_valid !== vis || req_x !== (vis ? CW'(mh) : CW'(0)) ||
             req_y !== (vis ? CW'(mv) : CW'(0))) begin
            mismatched++;
            $display("FAIL req cyc %0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                     cyc, req_valid, req_x, req_y, vis, mh, mv);
         end
         compared++;
         if (line_start !== (mh == 0 && mv < VA) || frame_start !== (mh == 0 && mv == 0)) begin
            mismatched++;
            $display("FAIL pulses cyc %0d at (%0d,%0d): got ls=%b fs=%b", cyc, mh, mv,
                     line_start, frame_start);
         end
         if (sq.size() == LAT + 1) begin
            e = sq.pop_front();
            compared++;
            if ({hsync, vsync, blank_n, red, green, blue} !== e) begin
               mismatched++;
               $display("FAIL pixel cyc %0d: got hs=%b vs=%b bn=%b rgb=%h/%h/%h want hs=%b vs=%b bn=%b rgb=%h/%h/%h",
                        cyc, hsync, vsync, blank_n, red, green, blue,
                        e.hs, e.vs, e.vis, e.r, e.g, e.b);
            end
         end
         if (hsync === 1'b0 && hs_prev === 1'b1) hs_falls++;
         if (hsync === 1'b0) hs_run++;
         else begin
            if (hs_run != 0 && hs_run != HS) hs_bad++;
            hs_run = 0;
         end
         hs_prev = hsync;
         if (vsync === 1'b0) vs_low++;
         if (line_start === 1'b1) ls_clk.push_back(cyc);
         if (frame_start === 1'b1) fs_en.push_back(en_cyc);

         p = pix(mh, mv);
         o.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
         o.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
         o.vis = vis;
         if (!vis) begin
            o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
         end else if (use_const) begin
            o.r = 8'hB6; o.g = 8'h6D; o.b = 8'hFF;
         end else begin
            o.r = ex3(p[7:5]); o.g = ex3(p[4:2]); o.b = ex2(p[1:0]);
         end
         sq.push_back(o);
         cx.push_back(mh);
         cy.push_back(mv);
         if (cx.size() == LAT + 1) begin
            qx = cx.pop_front();
            qy = cy.pop_front();
            colour_in = pix(qx, qy);
         end
         en_cyc++;
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
      end
      tick();
   endtask

   task automatic run_until(input int h, input int v);
      int n = 0;
      while (!(mh == h && mv == v) && n < 2 * HT * VT) begin
         cycle(1'b1);
         n++;
      end
      compared++;
      if (!(mh == h && mv == v)) begin
         mismatched++;
         $display("FAIL run_until: got (%0d,%0d) want (%0d,%0d)", mh, mv, h, v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ce = 1'b1; colour_in = 8'h00;
      tick(); tick();
      compared++;
      if (hsync !== 1'b1 || vsync !== 1'b1 || blank_n !== 1'b0 ||
          {red, green, blue} !== 24'h0 || frame_start !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_hold: got hs=%b vs=%b bn=%b rgb=%h fs=%b want 1 1 0 0 0",
                  hsync, vsync, blank_n, {red, green, blue}, frame_start);
      end
      reset = 1'b0;
      #1;
      compared++;
      if (req_valid !== 1'b1 || req_x !== '0 || req_y !== '0 ||
          frame_start !== 1'b1 || line_start !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_release: got v=%b (%0d,%0d) fs=%b ls=%b want 1 (0,0) 1 1",
                  req_valid, req_x, req_y, frame_start, line_start);
      end
      model_reset();
      clear_stats();
   endtask

   task automatic test_full_frame();
      for (int i = 0; i < HT * VT + 1; i++) cycle(1'b1);
      compared++;
      if (fs_en.size() != 2 || fs_en[0] != 0 || fs_en[1] != HT * VT) begin
         mismatched++;
         $display("FAIL frame_start_period: got %0d pulses, second at %0d want 2, %0d",
                  fs_en.size(), (fs_en.size() > 1) ? fs_en[1] : -1, HT * VT);
      end
      compared++;
      if (hs_falls != VT || hs_bad != 0) begin
         mismatched++;
         $display("FAIL hsync_runs: got %0d runs, %0d wrong length want %0d, 0",
                  hs_falls, hs_bad, VT);
      end
      compared++;
      if (vs_low != VS * HT) begin
         mismatched++;
         $display("FAIL vsync_low: got %0d want %0d", vs_low, VS * HT);
      end
   endtask

   task automatic test_expansion();
      do_reset();
      run_until(HA + LAT, 0);
      use_const = 1;
      for (int i = 0; i < 2 * HT; i++) cycle(1'b1);
      run_until(HA + LAT, 3);
      use_const = 0;
      for (int i = 0; i < HT; i++) cycle(1'b1);
   endtask

   task automatic test_ce_toggle();
      do_reset();
      for (int i = 0; i < 4 * HT; i++) begin
         cycle(1'b1);
         cycle(1'b0);
      end
      compared++;
      if (ls_clk.size() != 4) begin
         mismatched++;
         $display("FAIL ce_line_count: got %0d want 4", ls_clk.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            compared++;
            if (ls_clk[i] - ls_clk[i-1] != 2 * HT) begin
               mismatched++;
               $display("FAIL ce_line_period: got %0d want %0d",
                        ls_clk[i] - ls_clk[i-1], 2 * HT);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      run_until(8, 3);
      reset = 1'b1; ce = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      compared++;
      if (req_valid !== 1'b1 || req_x !== '0 || req_y !== '0 || frame_start !== 1'b1 ||
          hsync !== 1'b1 || vsync !== 1'b1 || blank_n !== 1'b0 ||
          {red, green, blue} !== 24'h0) begin
         mismatched++;
         $display("FAIL midframe_reset: got v=%b (%0d,%0d) fs=%b hs=%b vs=%b bn=%b rgb=%h",
                  req_valid, req_x, req_y, frame_start, hsync, vsync, blank_n,
                  {red, green, blue});
      end
      model_reset();
      clear_stats();
      for (int i = 0; i < 3 * HT; i++) cycle(1'b1);
   endtask

   initial begin
      cyc = 0;
      test_reset();
      test_full_frame();
      test_expansion();
      test_ce_toggle();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
